// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS IF stage: PC, imem req/ack fetch, one-entry stall hold buffer, redirect handling
// Optional feature macro: IF_JUMP_EARLY_EN (resolve j opcode in IF instead of waiting for the ID redirect)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] addr_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        flush_o
);

  localparam logic [0:0] S_FETCH   = 1'b0;
  localparam logic [0:0] S_DISCARD = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc_q;
  logic [31:0] disc_addr;    // address of the stale request being drained in S_DISCARD
  logic        hbuf_v;
  logic [31:0] hbuf_instr;
  logic [31:0] hbuf_pc4;

  logic [31:0] pc4;
  logic        present_mem;
  logic        present_buf;
  logic [31:0] pres_instr;
  logic [31:0] pres_pc4;
  logic [31:0] next_pc;

  // Request/handshake, presentation decode and next-PC selection
  always_comb begin
    pc4         = pc_q + 32'd4;
    imem_req_o  = !rst_i && !hbuf_v;
    imem_addr_o = (state == S_DISCARD) ? disc_addr : pc_q;

    present_buf = !rst_i && !branch_i && (state == S_FETCH) && hbuf_v && !stall_i;
    present_mem = !rst_i && !branch_i && (state == S_FETCH) && !hbuf_v && imem_ack_i && !stall_i;

    pres_instr  = hbuf_v ? hbuf_instr : imem_data_i;
    pres_pc4    = hbuf_v ? hbuf_pc4 : pc4;

    valid_o     = present_buf || present_mem;
    instr_o     = valid_o ? pres_instr : 32'h0000_0000;
    addr_o      = valid_o ? pres_pc4 : 32'h0000_0000;
    flush_o     = !rst_i && branch_i;

`ifdef IF_JUMP_EARLY_EN
    // Buffered words already advanced pc_q to their pc4, so the jump target simply overrides it
    if (pres_instr[31:26] == 6'b000010)
      next_pc = {pres_pc4[31:28], pres_instr[25:0], 2'b00};
    else
      next_pc = pres_pc4;
`else
    next_pc = pres_pc4;
`endif
  end

  // PC, discard FSM and hold-buffer update; redirect outranks stall and ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      state      <= S_FETCH;
      hbuf_v     <= 1'b0;
      disc_addr  <= RESET_PC;
      hbuf_instr <= 32'h0000_0000;
      hbuf_pc4   <= 32'h0000_0000;
    end else if (branch_i) begin
      pc_q   <= {branch_addr_i[31:2], 2'b00};
      hbuf_v <= 1'b0;
      if (state == S_FETCH) begin
        if (imem_req_o && !imem_ack_i) begin
          state     <= S_DISCARD;
          disc_addr <= pc_q;
        end
      end else if (imem_ack_i) begin
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (hbuf_v) begin
            if (!stall_i) begin
              hbuf_v <= 1'b0;
              pc_q   <= next_pc;
            end
          end else if (imem_ack_i) begin
            if (stall_i) begin
              hbuf_v     <= 1'b1;
              hbuf_instr <= imem_data_i;
              hbuf_pc4   <= pc4;
              pc_q       <= pc4;
            end else begin
              pc_q <= next_pc;
            end
          end
        end
        default: begin
          if (imem_ack_i)
            state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b1;
  logic [31:0] imem_data;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        valid;
  logic        flush;
  logic        jmode = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: returns 0x2000_0000 + address, or a j instruction (target 0x100) at 0x8 in jump mode
  assign imem_data = (jmode && imem_addr == 32'h8) ? 32'h0800_0040 : (32'h2000_0000 + imem_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch), .branch_addr_i(branch_addr),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .addr_o(addr), .instr_o(instr), .valid_o(valid), .flush_o(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge (inputs are then set, checks made #1 later)
  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    nxt(); #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);

    // Zero-wait streaming: 0,4,8,C
    nxt(); rst = 1'b0; #1;
    chk("s0_req", {31'b0, imem_req}, 32'h1);
    chk("s0_iaddr", imem_addr, 32'h0);
    chk("s0_valid", {31'b0, valid}, 32'h1);
    chk("s0_addr", addr, 32'h4);
    chk("s0_instr", instr, 32'h2000_0000);
    nxt(); #1;
    chk("s1_iaddr", imem_addr, 32'h4);
    chk("s1_addr", addr, 32'h8);
    nxt(); #1;
    chk("s2_iaddr", imem_addr, 32'h8);
    chk("s2_addr", addr, 32'hC);
    nxt(); #1;
    chk("s3_iaddr", imem_addr, 32'hC);

    // Stall 3 cycles at 0x10
    nxt(); stall = 1'b1; #1;
    chk("st0_iaddr", imem_addr, 32'h10);
    chk("st0_req", {31'b0, imem_req}, 32'h1);
    chk("st0_valid", {31'b0, valid}, 32'h0);
    chk("st0_instr", instr, 32'h0);
    nxt(); #1;
    chk("st1_req", {31'b0, imem_req}, 32'h0);
    chk("st1_valid", {31'b0, valid}, 32'h0);
    nxt(); #1;
    chk("st2_req", {31'b0, imem_req}, 32'h0);
    nxt(); stall = 1'b0; #1;
    chk("rel_valid", {31'b0, valid}, 32'h1);
    chk("rel_instr", instr, 32'h2000_0010);
    chk("rel_addr", addr, 32'h14);
    chk("rel_req", {31'b0, imem_req}, 32'h0);
    nxt(); #1;
    chk("res_iaddr", imem_addr, 32'h14);
    chk("res_instr", instr, 32'h2000_0014);
    nxt(); #1;
    chk("x18_iaddr", imem_addr, 32'h18);
    nxt(); #1;
    chk("x1c_iaddr", imem_addr, 32'h1C);

    // Branch at 0x20 to 0x100
    nxt(); branch = 1'b1; branch_addr = 32'h100; #1;
    chk("br_iaddr", imem_addr, 32'h20);
    chk("br_flush", {31'b0, flush}, 32'h1);
    chk("br_valid", {31'b0, valid}, 32'h0);
    chk("br_instr", instr, 32'h0);
    nxt(); branch = 1'b0; #1;
    chk("bt_iaddr", imem_addr, 32'h100);
    chk("bt_flush", {31'b0, flush}, 32'h0);
    chk("bt_instr", instr, 32'h2000_0100);

    // Wait-state memory, branch to 0x40 in second wait cycle
    nxt(); imem_ack = 1'b0; #1;
    chk("w0_iaddr", imem_addr, 32'h104);
    chk("w0_valid", {31'b0, valid}, 32'h0);
    nxt(); branch = 1'b1; branch_addr = 32'h40; #1;
    chk("w1_flush", {31'b0, flush}, 32'h1);
    nxt(); branch = 1'b0; #1;
    chk("w2_iaddr", imem_addr, 32'h104);
    chk("w2_req", {31'b0, imem_req}, 32'h1);
    nxt(); imem_ack = 1'b1; #1;
    chk("w3_iaddr", imem_addr, 32'h104);
    chk("w3_valid", {31'b0, valid}, 32'h0);
    nxt(); #1;
    chk("w4_iaddr", imem_addr, 32'h40);
    chk("w4_valid", {31'b0, valid}, 32'h1);
    chk("w4_instr", instr, 32'h2000_0040);

    // Wrap: branch to 0xFFFF_FFFF (low bits forced off)
    nxt(); branch = 1'b1; branch_addr = 32'hFFFF_FFFF; #1;
    nxt(); branch = 1'b0; #1;
    chk("wr_iaddr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_addr", addr, 32'h0);
    nxt(); #1;
    chk("wr_next", imem_addr, 32'h0);

    // Reset mid-wait
    nxt(); imem_ack = 1'b0; #1;
    chk("rw_iaddr", imem_addr, 32'h4);
    nxt(); rst = 1'b1; #1;
    chk("rw_req", {31'b0, imem_req}, 32'h0);
    chk("rw_valid", {31'b0, valid}, 32'h0);
    nxt(); rst = 1'b0; imem_ack = 1'b1; jmode = 1'b1; #1;
    chk("rw_next", imem_addr, 32'h0);
    chk("rw_nreq", {31'b0, imem_req}, 32'h1);

    // Jump at 0x8: early resolution only when the feature is built in
    nxt(); #1;
    chk("j_pre", imem_addr, 32'h4);
    nxt(); #1;
    chk("j_iaddr", imem_addr, 32'h8);
    chk("j_instr", instr, 32'h0800_0040);
    chk("j_flush", {31'b0, flush}, 32'h0);
    nxt(); #1;
`ifdef IF_JUMP_EARLY_EN
    chk("j_next", imem_addr, 32'h100);
`else
    chk("j_next", imem_addr, 32'hC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
